// File: rtl/rv_mul.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU.
// One Booth digit per cycle; fixed latency of WID/2+3 cycles from accept to done_o.
module rv_mul #(
    parameter int unsigned WID = 64
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           vld_i,
    input  logic [1:0]     fn_i,
    input  logic [WID-1:0] op1_i,
    input  logic [WID-1:0] op2_i,
    output logic [WID-1:0] res_o,
    output logic           done_o,
    output logic           ready_o
);

    localparam int unsigned CW = $clog2(WID / 2 + 1);

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_SAMP = 4'b0010;
    localparam logic [3:0] S_MUL  = 4'b0100;
    localparam logic [3:0] S_OUT  = 4'b1000;

    logic [3:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [WID+3:0] r_h;
    logic [WID+1:0] r_l;
    logic           r_bprev;
    logic [WID-1:0] r_op1;
    logic [WID-1:0] r_op2;
    logic [1:0]     r_fn;
    logic [WID-1:0] r_res;
    logic           r_done;
    logic           r_ready;

    logic             w_sgn1;
    logic             w_sgn2;
    logic [WID+1:0]   w_a;
    logic [WID+1:0]   w_b;
    logic [WID+3:0]   w_a4;
    logic [2:0]       w_grp;
    logic [WID+3:0]   w_pp;
    logic [WID+3:0]   w_hsum;
    logic [2*WID+5:0] w_shift;
    logic [WID-1:0]   w_hi;

    // fn 00 sign-extends both operands; the low half does not depend on it.
    assign w_sgn1 = (r_fn != 2'b11);
    assign w_sgn2 = ~r_fn[1];
    assign w_a    = {{2{w_sgn1 & r_op1[WID-1]}}, r_op1};
    assign w_b    = {{2{w_sgn2 & r_op2[WID-1]}}, r_op2};
    assign w_a4   = {{2{w_a[WID+1]}}, w_a};

    // r_bprev holds the multiplier bit shifted out by the previous step (B[2i-1]).
    assign w_grp = {r_l[1:0], r_bprev};

    always_comb begin
        w_pp = '0;
        case (w_grp)
            3'b001, 3'b010: w_pp = w_a4;
            3'b011:         w_pp = w_a4 << 1;
            3'b100:         w_pp = -(w_a4 << 1);
            3'b101, 3'b110: w_pp = -w_a4;
            default:        w_pp = '0;
        endcase
    end

    assign w_hsum  = r_h + w_pp;
    assign w_shift = {{2{w_hsum[WID+3]}}, w_hsum, r_l[WID+1:2]};
    assign w_hi    = {r_h[WID-3:0], r_l[WID+1:WID]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_h     <= '0;
            r_l     <= '0;
            r_bprev <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_fn    <= 2'b00;
            r_res   <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (vld_i && r_ready) begin
                        r_op1   <= op1_i;
                        r_op2   <= op2_i;
                        r_fn    <= fn_i;
                        r_ready <= 1'b0;
                        r_state <= S_SAMP;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_SAMP: begin
                    r_cnt   <= '0;
                    r_h     <= '0;
                    r_l     <= w_b;
                    r_bprev <= 1'b0;
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    r_h     <= w_shift[2*WID+5:WID+2];
                    r_l     <= w_shift[WID+1:0];
                    r_bprev <= r_l[1];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WID / 2)) begin
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    r_res   <= (r_fn == 2'b00) ? r_l[WID-1:0] : w_hi;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign res_o   = r_res;
    assign done_o  = r_done;
    assign ready_o = r_ready;

endmodule

// File: tb/tb_rv_mul.sv
// Self-checking bench for rv_mul: directed corner cases, randomized operations against
// a 128-bit arithmetic product model, handshake behaviour and asynchronous reset abort.
module tb_rv_mul;

    logic        clk;
    logic        rstn;
    logic        vld_i;
    logic [1:0]  fn_i;
    logic [63:0] op1_i;
    logic [63:0] op2_i;
    logic [63:0] res_o;
    logic        done_o;
    logic        ready_o;

    int checks;
    int failures;

    rv_mul #(.WID(64)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .vld_i   (vld_i),
        .fn_i    (fn_i),
        .op1_i   (op1_i),
        .op2_i   (op2_i),
        .res_o   (res_o),
        .done_o  (done_o),
        .ready_o (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full product from plain wide arithmetic, then pick the requested half.
    function automatic logic [63:0] model(input logic [1:0] fn, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0] x;
        logic [127:0] y;
        logic [127:0] p;
        x = (fn != 2'b11 && a[63]) ? {64'hFFFF_FFFF_FFFF_FFFF, a} : {64'h0, a};
        y = (fn[1] == 1'b0 && b[63]) ? {64'hFFFF_FFFF_FFFF_FFFF, b} : {64'h0, b};
        p = x * y;
        return (fn == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!ready_o && w < 100) begin
            tick();
            w++;
        end
        if (!ready_o) chk({tag, "_ready_timeout"}, {63'h0, ready_o}, 64'd1);
    endtask

    // One request; inputs are scrambled right after acceptance to prove they were latched.
    task automatic run(input string tag, input logic [1:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp);
        int lat;
        wait_ready(tag);
        vld_i = 1'b1;
        fn_i  = fn;
        op1_i = a;
        op2_i = b;
        tick();
        vld_i = 1'b0;
        op1_i = {$urandom, $urandom};
        op2_i = {$urandom, $urandom};
        fn_i  = 2'($urandom);
        chk({tag, "_busy"}, {63'h0, ready_o}, 64'd0);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done_o) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'd35);
        chk({tag, "_res"}, res_o, exp);
        tick();
        chk({tag, "_pulse"}, {63'h0, done_o}, 64'd0);
    endtask

    initial begin
        int ndone;
        int first_c;
        int second_c;
        logic [1:0]  rf;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] hold_exp;

        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        vld_i    = 1'b0;
        fn_i     = 2'b00;
        op1_i    = '0;
        op2_i    = '0;

        #2;
        chk("rst_res", res_o, 64'd0);
        chk("rst_done", {63'h0, done_o}, 64'd0);
        chk("rst_ready", {63'h0, ready_o}, 64'd0);
        #10;
        rstn = 1'b1;
        #1;
        chk("rel_ready_pre", {63'h0, ready_o}, 64'd0);
        tick();
        chk("rel_ready_edge", {63'h0, ready_o}, 64'd1);

        run("mul_m3x7", 2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run("mulh_m3x7", 2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        run("mulh_min", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
            64'h4000_0000_0000_0000);
        run("mul_min", 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0);
        run("mulhu_max", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE);
        run("mul_max", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run("mulhsu_m1", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFF);
        run("mul_zero", 2'b00, 64'h1234, 64'd0, 64'd0);

        for (int i = 0; i < 24; i++) begin
            rf = 2'($urandom);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 4 == 1) ra[63:16] = {48{ra[15]}};
            if (i % 4 == 2) rb[63:8] = {56{rb[7]}};
            run($sformatf("rnd%0d_fn%0d", i, rf), rf, ra, rb, model(rf, ra, rb));
        end

        // vld_i held high: accepts at E0 and E36, results at 35 and 71.
        wait_ready("hold");
        hold_exp = model(2'b10, 64'h8765_4321_0FED_CBA9, 64'hF00D_CAFE_1234_5678);
        vld_i = 1'b1;
        fn_i  = 2'b10;
        op1_i = 64'h8765_4321_0FED_CBA9;
        op2_i = 64'hF00D_CAFE_1234_5678;
        tick();
        ndone    = 0;
        first_c  = -1;
        second_c = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (done_o) begin
                ndone++;
                if (ndone == 1) first_c = c;
                if (ndone == 2) second_c = c;
                chk($sformatf("hold_res_c%0d", c), res_o, hold_exp);
            end
        end
        vld_i = 1'b0;
        chk("hold_count", 64'(ndone), 64'd2);
        chk("hold_first", 64'(first_c), 64'd35);
        chk("hold_second", 64'(second_c), 64'd71);

        run("pre_rst", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE);

        // Abort at cycle 10 of the multiply phase.
        wait_ready("abort");
        vld_i = 1'b1;
        fn_i  = 2'b11;
        op1_i = 64'hDEAD_BEEF_0000_0001;
        op2_i = 64'h0000_0000_0000_0003;
        tick();
        vld_i = 1'b0;
        tick();
        repeat (10) tick();
        rstn = 1'b0;
        #1;
        chk("abort_res", res_o, 64'd0);
        chk("abort_ready", {63'h0, ready_o}, 64'd0);
        chk("abort_done", {63'h0, done_o}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("abort_hold_done%0d", c), {63'h0, done_o}, 64'd0);
        end
        rstn = 1'b1;
        #1;
        chk("abort_rel_ready_pre", {63'h0, ready_o}, 64'd0);
        tick();
        chk("abort_rel_ready", {63'h0, ready_o}, 64'd1);
        for (int c = 0; c < 40; c++) begin
            if (done_o) chk("abort_stale_done", {63'h0, done_o}, 64'd0);
            if (c < 39) tick();
        end
        run("post_mulhu_5x6", 2'b11, 64'd5, 64'd6, 64'd0);
        run("post_mul_5x6", 2'b00, 64'd5, 64'd6, 64'd30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
